// File: rtl/alu_pkg.sv
// Shared ALU definitions: multiplier FSM encoding, widths and result-mux op codes.
package alu_pkg;

    localparam int unsigned MUL_WIDTH = 32;
    localparam int unsigned MUL_CNT_W = 6;

    // 8:1 result-mux select width and the codes the multiplier feeds
    localparam int unsigned ALU_OP_W = 3;
    localparam logic [ALU_OP_W-1:0] ALU_OP_MUL  = 3'b110;
    localparam logic [ALU_OP_W-1:0] ALU_OP_MULH = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } mult_state_e;

endpackage : alu_pkg

// File: rtl/adder_32bit_cout.sv
// Ripple-carry adder with carry-out; used for the shift-add partial sum.
module adder_32bit_cout #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_sum_c,
    output logic             o_cout_c
);

    // Bit-serial carry chain, LSB first
    always_comb begin : ripple
        logic v_carry;
        o_sum_c  = '0;
        o_cout_c = 1'b0;
        v_carry  = 1'b0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            o_sum_c[i] = i_a[i] ^ i_b[i] ^ v_carry;
            v_carry    = (i_a[i] & i_b[i]) | (i_a[i] & v_carry) | (i_b[i] & v_carry);
        end
        o_cout_c = v_carry;
    end

endmodule : adder_32bit_cout

// File: rtl/seq_mult_32bit.sv
// Unsigned shift-add multiplier, one multiplier bit per clock, fixed latency.
module seq_mult_32bit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_WIDTH,
    parameter int unsigned CNT_W = MUL_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product_hi,
    output logic [WIDTH-1:0] product_lo
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    mult_state_e      r_state;
    mult_state_e      w_state_next;
    logic             w_load;
    logic             w_last;

    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_product_hi;
    logic [WIDTH-1:0] r_product_lo;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_addend;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic [WIDTH-1:0] w_acc_hi_next;
    logic [WIDTH-1:0] w_acc_lo_next;

    // Add the multiplicand only when the current multiplier bit is set
    assign w_addend = r_acc_lo[0] ? r_mcand : '0;

    adder_32bit_cout #(
        .WIDTH (WIDTH)
    ) u_adder (
        .i_a      (r_acc_hi),
        .i_b      (w_addend),
        .o_sum_c  (w_sum),
        .o_cout_c (w_cout)
    );

    // Right shift of {cout, sum, acc_lo[W-1:1]} keeps the adder carry
    assign w_acc_hi_next = {w_cout, w_sum[WIDTH-1:1]};
    assign w_acc_lo_next = {w_sum[0], r_acc_lo[WIDTH-1:1]};

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and load decode; start is only honoured in IDLE or DONE
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_RUN;
                    w_load       = 1'b1;
                end
            end
            ST_RUN: begin
                if (r_cnt == LAST_CNT) begin
                    w_state_next = ST_DONE;
                    w_last       = 1'b1;
                end
            end
            ST_DONE: begin
                if (start) begin
                    w_state_next = ST_RUN;
                    w_load       = 1'b1;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath, counter, result capture and registered status flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mcand      <= '0;
            r_acc_hi     <= '0;
            r_acc_lo     <= '0;
            r_cnt        <= '0;
            r_product_hi <= '0;
            r_product_lo <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_busy <= (w_state_next == ST_RUN);
            r_done <= (w_state_next == ST_DONE);
            if (w_load) begin
                r_mcand  <= a;
                r_acc_hi <= '0;
                r_acc_lo <= b;
                r_cnt    <= '0;
            end else if (r_state == ST_RUN) begin
                r_acc_hi <= w_acc_hi_next;
                r_acc_lo <= w_acc_lo_next;
                r_cnt    <= r_cnt + CNT_W'(1);
                if (w_last) begin
                    r_product_hi <= w_acc_hi_next;
                    r_product_lo <= w_acc_lo_next;
                end
            end
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign product_hi = r_product_hi;
    assign product_lo = r_product_lo;

endmodule : seq_mult_32bit

// File: tb/tb_seq_mult_32bit.sv
// Directed self-checking bench for seq_mult_32bit.
module tb_seq_mult_32bit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] product_hi;
    logic [31:0] product_lo;

    int n_tests;
    int n_fail;

    seq_mult_32bit u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .product_hi (product_hi),
        .product_lo (product_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Start an op in the current cycle (cycle 0); returns in the DONE cycle.
    // glitch_cyc: cycle in which start is re-pulsed with a=b=7 (ignored by DUT).
    // rst_cyc: cycle in which rst_n is pulled low; the op is then abandoned.
    task automatic run_op(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                          input logic [63:0] exp_p, input logic [63:0] prev_p,
                          input int glitch_cyc, input int rst_cyc);
        int   cyc;
        logic busy_ok;
        logic hold_ok;
        a     = ia;
        b     = ib;
        start = 1'b1;
        tick();
        start   = 1'b0;
        cyc     = 1;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if ({product_hi, product_lo} !== prev_p) hold_ok = 1'b0;
            start = (cyc == glitch_cyc);
            if (cyc == glitch_cyc) begin
                a = 32'd7;
                b = 32'd7;
            end
            if (cyc == rst_cyc) begin
                rst_n = 1'b0;
                tick();
                check({tag, "_rst_busy"}, 64'(busy), 64'd0);
                check({tag, "_rst_done"}, 64'(done), 64'd0);
                check({tag, "_rst_prod"}, {product_hi, product_lo}, 64'd0);
                rst_n = 1'b1;
                return;
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        check({tag, "_latency"}, 64'(cyc), 64'd33);
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_busy_off"}, 64'(busy), 64'd0);
        check({tag, "_busy_run"}, 64'(busy_ok), 64'd1);
        check({tag, "_hold"}, 64'(hold_ok), 64'd1);
        check({tag, "_prod"}, {product_hi, product_lo}, exp_p);
    endtask

    // One cycle after DONE with no start: back to IDLE, result held
    task automatic post_done(input string tag, input logic [63:0] exp_p);
        tick();
        check({tag, "_pulse"}, 64'(done), 64'd0);
        check({tag, "_idle"}, 64'(busy), 64'd0);
        check({tag, "_keep"}, {product_hi, product_lo}, exp_p);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        tick();
        tick();
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_prod", {product_hi, product_lo}, 64'd0);
        rst_n = 1'b1;
        tick();

        // 3*5
        run_op("t1", 32'd3, 32'd5, 64'h0000_0000_0000_000F, 64'd0, -1, -1);
        post_done("t1", 64'h0000_0000_0000_000F);

        // all-ones squared exercises the carry-out
        run_op("t2", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001,
               64'h0000_0000_0000_000F, -1, -1);
        post_done("t2", 64'hFFFF_FFFE_0000_0001);

        // zero multiplier: same latency, old product held until DONE
        run_op("t3", 32'h1234_5678, 32'd0, 64'd0, 64'hFFFF_FFFE_0000_0001, -1, -1);
        post_done("t3", 64'd0);

        // start re-pulsed mid-run with 7*7 is ignored
        run_op("t4", 32'd2, 32'd3, 64'd6, 64'd0, 10, -1);
        post_done("t4", 64'd6);

        // reset in cycle 15 discards the run and clears the product
        run_op("t5a", 32'd9, 32'd9, 64'd81, 64'd6, -1, 15);
        tick();
        check("t5_idle_busy", 64'(busy), 64'd0);
        run_op("t5b", 32'd2, 32'd2, 64'd4, 64'd0, -1, -1);
        post_done("t5b", 64'd4);

        // back-to-back: start held in the DONE cycle of 5*6
        run_op("t6a", 32'd5, 32'd6, 64'd30, 64'd4, -1, -1);
        run_op("t6b", 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 64'd30, -1, -1);
        post_done("t6b", 64'h0000_0001_0000_0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_seq_mult_32bit
